vedic_mult_seq: RTL



---
 rtl/vedic_mult_seq.sv | 134 +++++++++++++
 1 files changed

// File: rtl/vedic_mult_seq.sv
// Sequential radix-4 multiplier: consumes one 2-bit digit of b per cycle using 2x2 vedic cells.
// Optional signed mode is enabled by defining VEDIC_SIGNED_EN, which adds the is_signed port.
module vedic_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef VEDIC_SIGNED_EN
    input  logic               is_signed,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int DIGITS = WIDTH / 2;
    localparam int CNT_W  = $clog2(DIGITS);
    localparam int PW     = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [CNT_W-1:0] cnt_q;
    logic [PW-1:0]    acc_q, acc_d, pp, final_d, product_q;
    logic             in_ready_q, out_valid_q, busy_q;
    logic [WIDTH-1:0] a_cap, b_cap;
    logic [1:0]       digit;
    logic             t0, t1, t2, t3, s1, c1, s2, c2;
`ifdef VEDIC_SIGNED_EN
    logic             neg_q, neg_cap;
`endif

    // Signed operands are stored as magnitudes; the most negative value maps onto itself unsigned.
    always_comb begin
        a_cap = a;
        b_cap = b;
`ifdef VEDIC_SIGNED_EN
        neg_cap = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        if (is_signed && a[WIDTH-1]) a_cap = -a;
        if (is_signed && b[WIDTH-1]) b_cap = -b;
`endif
    end

    always_comb begin
        pp    = '0;
        digit = b_q[1:0];
        t0 = 1'b0; t1 = 1'b0; t2 = 1'b0; t3 = 1'b0;
        s1 = 1'b0; c1 = 1'b0; s2 = 1'b0; c2 = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            t0 = a_q[2*i]   & digit[0];
            t1 = a_q[2*i+1] & digit[0];
            t2 = a_q[2*i]   & digit[1];
            t3 = a_q[2*i+1] & digit[1];
            s1 = t1 ^ t2;
            c1 = t1 & t2;
            s2 = t3 ^ c1;
            c2 = t3 & c1;
            pp = pp + (PW'({c2, s2, s1, t0}) << (2 * i));
        end
        acc_d = acc_q + (pp << {cnt_q, 1'b0});
`ifdef VEDIC_SIGNED_EN
        final_d = neg_q ? -acc_d : acc_d;
`else
        final_d = acc_d;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            product_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef VEDIC_SIGNED_EN
            neg_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a_cap;
                        b_q        <= b_cap;
                        cnt_q      <= '0;
                        acc_q      <= '0;
                        state_q    <= BUSY;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
`ifdef VEDIC_SIGNED_EN
                        neg_q      <= neg_cap;
`endif
                    end
                end
                BUSY: begin
                    acc_q <= acc_d;
                    b_q   <= b_q >> 2;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        product_q   <= final_d;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        product_q   <= '0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign busy      = busy_q;

endmodule
